// File: rtl/classifi_pkg.sv
// classifi_pkg: shared constants, class index type and sequencer state encoding
package classifi_pkg;
    localparam int N_CLASS = 5;
    localparam int DATA_W  = 60;
    typedef logic [2:0] cls_idx_t;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DECIDE, OUT} state_t;
endpackage

// File: rtl/vote_argmax.sv
// vote_argmax: combinational argmax over per-class vote counters, lowest index wins ties
module vote_argmax
    import classifi_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic [N_CLASS-1:0][CNT_W-1:0] cnt_i,
    output cls_idx_t                      idx_o,
    output logic [N_CLASS-1:0]            onehot_o,
    output logic                          none_o
);
    logic [CNT_W-1:0] max_v;

    always_comb begin
        idx_o = '0;
        max_v = cnt_i[0];
        for (int i = 1; i < N_CLASS; i++)
            if (cnt_i[i] > max_v) begin
                idx_o = cls_idx_t'(i);
                max_v = cnt_i[i];
            end
        none_o   = max_v == '0;
        onehot_o = none_o ? '0 : N_CLASS'(1) << idx_o;
    end
endmodule

// File: rtl/classifi_vote_ctrl.sv
// classifi_vote_ctrl: feeds samples to the classifier, tallies one-hot votes per frame
// and hands a majority-vote label downstream.
module classifi_vote_ctrl
    import classifi_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_din_valid,
    input  logic [DATA_W-1:0]  i_din,
    output logic               o_din_ready,
    output logic               o_cls_enable,
    output logic [DATA_W-1:0]  o_cls_din,
    input  logic [N_CLASS-1:0] i_cls_onehot,
    output logic               o_busy,
    output logic               o_result_valid,
    output logic [N_CLASS-1:0] o_result,
    output cls_idx_t           o_result_idx,
    output logic               o_result_none,
    output logic [CNT_W-1:0]   o_no_match_cnt,
    input  logic               i_result_ready
);
    state_t                       state_q, state_d;
    logic                         hs, last, single, tag1_q, tag2_q;
    logic [CNT_W-1:0]             sample_cnt_q, nm_q;
    logic [N_CLASS-1:0][CNT_W-1:0] votes_q;
    cls_idx_t                     win_idx;
    logic [N_CLASS-1:0]           win_oh;
    logic                         win_none;

    assign o_din_ready = state_q == RUN;
    assign o_busy      = state_q != IDLE;
    assign hs          = i_din_valid & o_din_ready;
    assign last        = hs && sample_cnt_q == CNT_W'(FRAME_LEN - 1);
    assign single      = |i_cls_onehot && !(|(i_cls_onehot & (i_cls_onehot - N_CLASS'(1))));

    vote_argmax #(.CNT_W(CNT_W)) u_argmax (
        .cnt_i   (votes_q),
        .idx_o   (win_idx),
        .onehot_o(win_oh),
        .none_o  (win_none)
    );

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;

    // Leaving DRAIN once tag1 is empty means both tags are empty on entry to DECIDE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_start ? RUN : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            DRAIN:   state_d = tag1_q ? DRAIN : DECIDE;
            DECIDE:  state_d = OUT;
            OUT:     state_d = i_result_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cls_enable   <= 1'b0;
            o_cls_din      <= '0;
            tag1_q         <= 1'b0;
            tag2_q         <= 1'b0;
            sample_cnt_q   <= '0;
            nm_q           <= '0;
            votes_q        <= '0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            o_result_idx   <= '0;
            o_result_none  <= 1'b0;
            o_no_match_cnt <= '0;
        end else begin
            o_cls_enable <= hs;
            tag1_q       <= hs;
            tag2_q       <= tag1_q;
            if (hs) o_cls_din <= i_din;
            if (state_q == IDLE && i_start) begin
                sample_cnt_q   <= '0;
                nm_q           <= '0;
                votes_q        <= '0;
                o_no_match_cnt <= '0;
            end else begin
                if (hs) sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                if (tag2_q && !single) nm_q <= nm_q + CNT_W'(1);
                for (int c = 0; c < N_CLASS; c++)
                    if (tag2_q && i_cls_onehot == (N_CLASS'(1) << c))
                        votes_q[c] <= votes_q[c] + CNT_W'(1);
            end
            if (state_q == DECIDE) begin
                o_result       <= win_oh;
                o_result_idx   <= win_idx;
                o_result_none  <= win_none;
                o_no_match_cnt <= nm_q;
                o_result_valid <= 1'b1;
            end
            if (state_q == OUT && i_result_ready) o_result_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_classifi_vote_ctrl.sv
// tb_classifi_vote_ctrl: scoreboard bench with a registered classifier model that
// echoes the low N_CLASS bits of each sample as its one-hot label.
module tb_classifi_vote_ctrl;
    import classifi_pkg::*;
    localparam int FL = 8;
    localparam int CW = $clog2(FL + 1);

    typedef struct {
        logic [N_CLASS-1:0] res;
        logic [2:0]         idx;
        logic               none;
        logic [CW-1:0]      nm;
    } exp_t;
    typedef logic [N_CLASS-1:0] lab_t [FL];

    logic               clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_din_valid = 1'b0, i_result_ready = 1'b0;
    logic [DATA_W-1:0]  i_din = '0;
    logic               o_din_ready, o_cls_enable, o_busy, o_result_valid, o_result_none;
    logic [DATA_W-1:0]  o_cls_din;
    logic [N_CLASS-1:0] i_cls_onehot, o_result, cls_q;
    cls_idx_t           o_result_idx;
    logic [CW-1:0]      o_no_match_cnt;

    int checks = 0, failures = 0, en_cnt = 0, acc_cnt = 0, cyc = 0;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] din_q[$];

    classifi_vote_ctrl #(.FRAME_LEN(FL)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_din_valid(i_din_valid), .i_din(i_din),
        .o_din_ready(o_din_ready), .o_cls_enable(o_cls_enable), .o_cls_din(o_cls_din),
        .i_cls_onehot(i_cls_onehot), .o_busy(o_busy), .o_result_valid(o_result_valid),
        .o_result(o_result), .o_result_idx(o_result_idx), .o_result_none(o_result_none),
        .o_no_match_cnt(o_no_match_cnt), .i_result_ready(i_result_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk or posedge i_rst)
        if (i_rst) cls_q <= '0;
        else if (o_cls_enable) cls_q <= o_cls_din[N_CLASS-1:0];
    assign i_cls_onehot = cls_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input lab_t lab);
        int   v[N_CLASS];
        int   nm = 0, best = 0;
        exp_t e;
        foreach (v[c]) v[c] = 0;
        for (int k = 0; k < FL; k++)
            if ($countones(lab[k]) == 1) begin
                for (int c = 0; c < N_CLASS; c++) if (lab[k][c]) v[c]++;
            end else nm++;
        for (int c = 1; c < N_CLASS; c++) if (v[c] > v[best]) best = c;
        e.none = v[best] == 0;
        e.idx  = e.none ? 3'd0 : 3'(best);
        e.res  = e.none ? '0 : N_CLASS'(1 << best);
        e.nm   = CW'(nm);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (o_cls_enable) begin
            en_cnt++;
            chk("din_q_nonempty", din_q.size() != 0, 1);
            if (din_q.size() != 0) chk("cls_din", o_cls_din, din_q.pop_front());
        end
        if (o_result_valid && i_result_ready) begin
            acc_cnt++;
            chk("exp_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", o_result, e.res);
                chk("result_idx", o_result_idx, e.idx);
                chk("result_none", o_result_none, e.none);
                chk("no_match_cnt", o_no_match_cnt, e.nm);
            end
        end
    end

    task automatic feed(input lab_t lab, input int n, input bit toggle, input bit noise);
        int k = 0;
        bit ph = 1'b1, hs;
        for (int it = 0; it < 200 && k < n; it++) begin
            i_din_valid = toggle ? ph : 1'b1;
            ph          = !ph;
            i_din       = {55'({$urandom, $urandom}), lab[k]};
            i_start     = noise && k == 3;
            hs          = i_din_valid && o_din_ready;
            if (hs) din_q.push_back(i_din);
            @(posedge clk); #1;
            if (hs) k++;
        end
        i_din_valid = 1'b0;
        i_start     = 1'b0;
        chk("fed", k, n);
    endtask

    task automatic run_frame(input lab_t lab, input bit toggle, input int stall, input bit noise, input bit lat);
        exp_t e;
        int   t0, n;
        e = model(lab);
        exp_q.push_back(e);
        en_cnt = 0;
        i_result_ready = stall == 0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        t0 = cyc;
        feed(lab, FL, toggle, noise);
        n = 0;
        while (!o_result_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_seen", o_result_valid, 1);
        if (lat) chk("latency", cyc - t0, FL + 3);
        i_start = noise;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", o_result_valid, 1);
            chk("stall_res", o_result, e.res);
            chk("stall_idx", o_result_idx, e.idx);
            chk("stall_none", o_result_none, e.none);
            @(posedge clk); #1;
        end
        i_result_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("valid_clr", o_result_valid, 0);
        chk("idle", o_busy, 0);
        chk("en_pulses", en_cnt, FL);
        if (noise) begin
            repeat (3) @(posedge clk);
            #1;
            chk("noise_idle", o_busy, 0);
            chk("noise_no_valid", o_result_valid, 0);
        end
    endtask

    initial begin
        lab_t l;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_din_ready, 0);
        chk("rst_valid", o_result_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_nm", o_no_match_cnt, 0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        l = '{5'b00100, 5'b00001, 5'b00100, 5'b00001, 5'b00100, 5'b00100, 5'b00001, 5'b00100};
        run_frame(l, 1'b0, 0, 1'b0, 1'b1);
        l = '{5'b00001, 5'b01000, 5'b01000, 5'b00001, 5'b01000, 5'b00001, 5'b00001, 5'b01000};
        run_frame(l, 1'b0, 0, 1'b0, 1'b0);
        l = '{5'b00000, 5'b01010, 5'b00000, 5'b00000, 5'b00000, 5'b01010, 5'b00000, 5'b00000};
        run_frame(l, 1'b0, 0, 1'b0, 1'b0);
        l = '{5'b10000, 5'b00010, 5'b00000, 5'b10000, 5'b00010, 5'b10000, 5'b00010, 5'b00000};
        run_frame(l, 1'b1, 5, 1'b0, 1'b0);

        l = '{default: 5'b00010};
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        feed(l, 3, 1'b0, 1'b0);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_ready", o_din_ready, 0);
        chk("mid_rst_en", o_cls_enable, 0);
        chk("mid_rst_din", o_cls_din, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_valid", o_result_valid, 0);
        chk("mid_rst_result", o_result, 0);
        chk("mid_rst_idx", o_result_idx, 0);
        chk("mid_rst_none", o_result_none, 0);
        chk("mid_rst_nm", o_no_match_cnt, 0);
        din_q.delete();
        @(posedge clk); #1;
        i_rst = 1'b0;
        l = '{default: 5'b10000};
        run_frame(l, 1'b0, 0, 1'b0, 1'b1);

        l = '{5'b01000, 5'b00011, 5'b01000, 5'b00001, 5'b01000, 5'b00001, 5'b00000, 5'b00100};
        run_frame(l, 1'b0, 2, 1'b1, 1'b0);

        chk("accepted", acc_cnt, 6);
        chk("q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/classifi_vote_ctrl.md
Name: classifi_vote_ctrl

Overview:
Frame-level sequencer for the MRELBP single-sample classifier stage.
- Accepts a stream of 60-bit feature scores over a valid/ready handshake and pulses the classifier enable once per accepted sample.
- Collects the classifier's one-hot label outputs and keeps per-class vote counters over a frame of FRAME_LEN samples.
- At frame end, issues one majority-vote texture label downstream under a valid/ready handshake.

Parameters:
N_CLASS, 5, number of texture classes (one-hot width of classifier output)
DATA_W, 60, feature score width
FRAME_LEN, 64, samples per classification frame (>=1)
CNT_W, $clog2(FRAME_LEN+1), vote/sample counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  pulse: begin a new frame (honoured only in IDLE)
i_din_valid  in  1  feature sample valid
i_din  in  DATA_W  feature score (signed)
o_din_ready  out  1  controller can accept a sample
o_cls_enable  out  1  enable pulse to classifier stage
o_cls_din  out  DATA_W  registered sample to classifier
i_cls_onehot  in  N_CLASS  classifier registered one-hot label
o_busy  out  1  frame in progress (state != IDLE)
o_result_valid  out  1  frame result valid
o_result  out  N_CLASS  winning class, one-hot (0 if none)
o_result_idx  out  3  winning class index
o_result_none  out  1  no valid vote in frame
o_no_match_cnt  out  CNT_W  samples in last frame with invalid classifier output
i_result_ready  in  1  downstream accepts result

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0. All vote, sample, no-match and pipeline-tag registers cleared. Reset mid-frame discards the frame; no result is issued.
- States: IDLE, RUN, DRAIN, DECIDE, OUT.
- IDLE:
  - i_start=1: clear votes, sample_cnt and no-match count, then go to RUN.
  - i_start in any other state is ignored.
- RUN:
  - o_din_ready=1 (combinational from state).
  - Handshake = i_din_valid & o_din_ready. On handshake: o_cls_din<=i_din, o_cls_enable<=1 for exactly one cycle, sample_cnt++.
  - Gaps in i_din_valid are allowed.
  - When the handshake takes sample_cnt to FRAME_LEN, go to DRAIN; o_din_ready is low from the next cycle.
- Pipeline: handshake at cycle t; enable/din asserted at t+1; classifier output registered at end of t+1; i_cls_onehot sampled at t+2. A 2-stage valid tag tracks outstanding samples.
- Vote rule, per sampled i_cls_onehot:
  - Exactly one bit set: increment that class counter.
  - Zero bits or more than one bit set: increment no-match count.
  - Counters never exceed FRAME_LEN, so no saturation logic is required.
- DRAIN: wait until both tag stages are empty, then go to DECIDE. Minimum DRAIN is 2 cycles after the last handshake.
- DECIDE (1 cycle):
  - Argmax over vote counters; a tie resolves to the lowest index.
  - All votes 0: o_result=0, o_result_idx=0, o_result_none=1.
  - Register results, drive o_no_match_cnt, set o_result_valid=1, go to OUT.
- OUT:
  - Hold o_result, o_result_idx and o_result_none stable while i_result_ready=0.
  - On o_result_valid & i_result_ready: clear o_result_valid and go to IDLE.
  - o_result, o_result_idx and o_result_none keep their last values until the next DECIDE.
  - o_no_match_cnt persists until the next i_start.
- Latency: with i_din_valid continuous and i_result_ready=1, o_result_valid rises FRAME_LEN+3 cycles after the cycle i_start is sampled, and is accepted 1 cycle later.
- FRAME_LEN=1 is legal: RUN lasts exactly one handshake.

Decomposition:
- Shared package classifi_pkg:
  - N_CLASS, DATA_W constants.
  - class index typedef (logic [2:0]).
  - FSM state enum (IDLE, RUN, DRAIN, DECIDE, OUT).
- Sub-module vote_argmax: combinational argmax over N_CLASS counters of CNT_W bits. Returns index, one-hot and a none flag, with lowest-index tie-break.

Test Plan:
1. FRAME_LEN=8, bench classifier model returns 5'b00100 ×5 and 5'b00001 ×3, continuous valid -> o_result=5'b00100, idx=2, none=0, no_match_cnt=0, valid 11 cycles after start.
2. Four votes for class 0 and four for class 3 -> o_result=5'b00001, idx=0 (tie to lowest).
3. Classifier returns 5'b00000 ×6 and 5'b01010 ×2 -> o_result=0, none=1, no_match_cnt=8.
4. i_din_valid toggles 1/0 each cycle; i_result_ready held low 5 cycles after valid -> exactly 8 enable pulses; result stable for all 5 stall cycles; single acceptance; return to IDLE.
5. i_rst asserted after 3 handshakes -> all outputs 0 immediately. A new i_start runs a full 8-sample frame with only new-frame votes counted.
6. i_start pulsed during RUN and OUT -> ignored. Sample count stays 8 and exactly one result is issued.
